// File: rtl/score_keeper_if.sv
// Signal bundle between the round-victory detector / display side and score_keeper.
// gameFinished is a one-cycle valid strobe with no ready: winnerId is sampled only with it.
interface score_keeper_if;
  logic       gameFinished;
  logic       winnerId;
  logic [3:0] leftScore;
  logic [3:0] rightScore;
  logic [6:0] leftHex;
  logic [6:0] rightHex;
  logic       roundReset;
  logic       matchOver;
  logic       matchWinner;
  logic [1:0] dbgState;

  modport master (
    output gameFinished, winnerId,
    input  leftScore, rightScore, leftHex, rightHex,
    input  roundReset, matchOver, matchWinner, dbgState
  );

  modport slave (
    input  gameFinished, winnerId,
    output leftScore, rightScore, leftHex, rightHex,
    output roundReset, matchOver, matchWinner, dbgState
  );
endinterface

// File: rtl/score_keeper.sv
// Tug-of-war match score keeper: counts round wins, drives 7-seg digits, restarts rounds.
// Optional winner-digit blink is enabled with the SCORE_BLINK_EN macro.
module score_keeper #(
  parameter int WIN_SCORE    = 7,
  parameter int HOLD_CYCLES  = 4,
  parameter int BLINK_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  score_keeper_if.slave  sk
);

  if (WIN_SCORE < 1 || WIN_SCORE > 9 || HOLD_CYCLES < 1 || BLINK_CYCLES < 1) begin : gBadParams
    $error("score_keeper: parameter out of range");
  end

  typedef enum logic [1:0] {
    PLAYING    = 2'd0,
    CELEBRATE  = 2'd1,
    MATCH_OVER = 2'd2
  } state_t;

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [3:0]    WIN       = 4'(WIN_SCORE);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  state_t        state, nextState;
  logic [3:0]    leftScore, rightScore;
  logic [HW-1:0] holdCnt;
  logic          winner;
  logic          roundReset;
  logic          accept;
  logic          finishRound;
  logic [3:0]    winnerScore;
  logic          blankWinner;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  assign winnerScore = winner ? rightScore : leftScore;

  // roundReset marks the playfield-clearing cycle, so strobes are refused while it is high.
  always_comb begin
    nextState   = state;
    accept      = 1'b0;
    finishRound = 1'b0;
    case (state)
      PLAYING: begin
        if (sk.gameFinished && !roundReset) begin
          accept    = 1'b1;
          nextState = CELEBRATE;
        end
      end
      CELEBRATE: begin
        if (holdCnt == '0) begin
          if (winnerScore == WIN) begin
            nextState = MATCH_OVER;
          end else begin
            nextState   = PLAYING;
            finishRound = 1'b1;
          end
        end
      end
      MATCH_OVER: nextState = MATCH_OVER;
      default:    nextState = PLAYING;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PLAYING;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leftScore  <= 4'd0;
      rightScore <= 4'd0;
      holdCnt    <= '0;
      winner     <= 1'b0;
      roundReset <= 1'b0;
    end else begin
      roundReset <= finishRound;
      if (accept) begin
        winner  <= sk.winnerId;
        holdCnt <= HOLD_LOAD;
        if (sk.winnerId) begin
          if (rightScore < WIN) rightScore <= rightScore + 4'd1;
        end else begin
          if (leftScore < WIN) leftScore <= leftScore + 4'd1;
        end
      end else if (state == CELEBRATE && holdCnt != '0) begin
        holdCnt <= holdCnt - 1'b1;
      end
    end
  end

`ifdef SCORE_BLINK_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0] blinkCnt;
  logic          blinkOff;

  // Counter restarts on each round win so every celebration opens with the digit visible.
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      blinkCnt <= '0;
      blinkOff <= 1'b0;
    end else if (state == CELEBRATE || state == MATCH_OVER) begin
      if (blinkCnt == BLINK_LAST) begin
        blinkCnt <= '0;
        blinkOff <= ~blinkOff;
      end else begin
        blinkCnt <= blinkCnt + 1'b1;
      end
    end
  end

  assign blankWinner = blinkOff && (state == CELEBRATE || state == MATCH_OVER);
`else
  assign blankWinner = 1'b0;
`endif

  assign sk.leftScore   = leftScore;
  assign sk.rightScore  = rightScore;
  assign sk.leftHex     = (blankWinner && !winner) ? 7'b1111111 : decode(leftScore);
  assign sk.rightHex    = (blankWinner &&  winner) ? 7'b1111111 : decode(rightScore);
  assign sk.roundReset  = roundReset;
  assign sk.matchOver   = (state == MATCH_OVER);
  assign sk.matchWinner = (state == MATCH_OVER) && winner;
  assign sk.dbgState    = state;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: vector table, directed match scenarios and
// randomized strobes against a timestamp-based reference model.
module tb_score_keeper;
  localparam int WIN   = 7;
  localparam int HOLD  = 4;
  localparam int BLINK = 2;
  localparam int NEVER = 1 << 30;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  score_keeper_if sk();

  score_keeper #(.WIN_SCORE(WIN), .HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK)) dut (
    .clk   (clk),
    .reset (reset),
    .sk    (sk)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: scores plus the edge numbers at which things are due to happen.
  int   k = 0;
  int   mL, mR;
  bit   mWin;
  int   rrEdge, overEdge, nextAcc, celebStart;
  logic [6:0] segTab [10];
  logic [7:0] exp_q [$];
  logic [3:0] prevL, prevR;

  typedef struct {
    bit         gf;
    bit         wid;
    logic [3:0] eL;
    logic [3:0] eR;
    logic       eRR;
    logic       eOver;
  } vec_t;
  vec_t tv [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h edge=%0d", name, act, exp, k);
    end
  endtask

  task automatic model_edge(input bit r, input bit gf, input bit w);
    k++;
    if (r) begin
      mL = 0; mR = 0; mWin = 0;
      rrEdge = -1; overEdge = -1; celebStart = -1;
      nextAcc = k + 1;
      exp_q.delete();
    end else if (gf && k >= nextAcc) begin
      mWin = w;
      if (w) begin
        if (mR < WIN) mR++;
      end else begin
        if (mL < WIN) mL++;
      end
      exp_q.push_back({4'(mL), 4'(mR)});
      celebStart = k;
      if ((w ? mR : mL) == WIN) begin
        overEdge = k + HOLD;
        nextAcc  = NEVER;
      end else begin
        rrEdge  = k + HOLD;
        nextAcc = k + HOLD + 2;
      end
    end
  endtask

  task automatic check_all();
    bit         overNow;
    bit         blinkOn;
    logic [6:0] expLH, expRH;
    overNow = (overEdge >= 0) && (k >= overEdge);
    blinkOn = 1'b0;
`ifdef SCORE_BLINK_EN
    if (celebStart >= 0 && (k < celebStart + HOLD || overNow) &&
        (((k - celebStart) / BLINK) % 2 == 1))
      blinkOn = 1'b1;
`endif
    expLH = (blinkOn && !mWin) ? 7'b1111111 : segTab[mL];
    expRH = (blinkOn &&  mWin) ? 7'b1111111 : segTab[mR];
    chk("leftScore",   sk.leftScore,   mL);
    chk("rightScore",  sk.rightScore,  mR);
    chk("leftHex",     sk.leftHex,     expLH);
    chk("rightHex",    sk.rightHex,    expRH);
    chk("roundReset",  sk.roundReset,  (k == rrEdge) ? 1 : 0);
    chk("matchOver",   sk.matchOver,   overNow ? 1 : 0);
    chk("matchWinner", sk.matchWinner, (overNow && mWin) ? 1 : 0);
  endtask

  // One clock: drive at negedge, update model at posedge, sample #1 later.
  task automatic step(input bit r, input bit gf, input bit w);
    logic [7:0] e;
    @(negedge clk);
    reset = r;
    sk.gameFinished = gf;
    sk.winnerId = w;
    @(posedge clk);
    model_edge(r, gf, w);
    #1;
    check_all();
    if (r) begin
      prevL = 4'd0;
      prevR = 4'd0;
    end else if ({sk.leftScore, sk.rightScore} !== {prevL, prevR}) begin
      if (exp_q.size() == 0) begin
        chk("sb_spurious", {sk.leftScore, sk.rightScore}, {prevL, prevR});
      end else begin
        e = exp_q.pop_front();
        chk("sb_score", {sk.leftScore, sk.rightScore}, e);
      end
      prevL = sk.leftScore;
      prevR = sk.rightScore;
    end
  endtask

  task automatic do_reset();
    step(1, 0, 0);
    step(1, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  initial begin
    segTab[0] = 7'b1000000; segTab[1] = 7'b1111001; segTab[2] = 7'b0100100;
    segTab[3] = 7'b0110000; segTab[4] = 7'b0011001; segTab[5] = 7'b0010010;
    segTab[6] = 7'b0000010; segTab[7] = 7'b1111000; segTab[8] = 7'b0000000;
    segTab[9] = 7'b0010000;
    sk.gameFinished = 1'b0;
    sk.winnerId = 1'b0;

    // Right win, roundReset HOLD edges later, strobe ignored in that cycle, then left win.
    tv[0] = '{1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0};
    tv[1] = '{1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0};
    tv[2] = '{1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0};
    tv[3] = '{1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0};
    tv[4] = '{1'b0, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0};
    tv[5] = '{1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0};
    tv[6] = '{1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0};
    tv[7] = '{1'b1, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0};

    do_reset();
    chk("reset_left",  sk.leftScore, 0);
    chk("reset_rhex",  sk.rightHex, 7'b1000000);
    for (int i = 0; i < 8; i++) begin
      step(0, tv[i].gf, tv[i].wid);
      chk("tv_left",  sk.leftScore,  tv[i].eL);
      chk("tv_right", sk.rightScore, tv[i].eR);
      chk("tv_rr",    sk.roundReset, tv[i].eRR);
      chk("tv_over",  sk.matchOver,  tv[i].eOver);
    end
    chk("tv_rhex", sk.rightHex, 7'b1111001);
    idle(HOLD + 2);

    // Held strobe counts once.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    idle(HOLD + 1);
    chk("t2_left",  sk.leftScore, 1);
    chk("t2_right", sk.rightScore, 0);

    // Alternating wins, three each.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(0, 1, (i % 2) ? 1'b1 : 1'b0);
      idle(HOLD + 1);
    end
    chk("t3_lhex", sk.leftHex, 7'b0110000);
    chk("t3_rhex", sk.rightHex, 7'b0110000);
    chk("t3_over", sk.matchOver, 0);

    // Seven right wins finish the match; later strobes are ignored.
    do_reset();
    for (int i = 0; i < WIN; i++) begin
      step(0, 1, 1);
      idle(HOLD + 1);
    end
    chk("t4_over",   sk.matchOver, 1);
    chk("t4_winner", sk.matchWinner, 1);
    chk("t4_right",  sk.rightScore, WIN);
    for (int i = 0; i < 4; i++) step(0, 1, 1'($urandom_range(0, 1)));
    chk("t4_frozen", {sk.leftScore, sk.rightScore}, {4'd0, 4'(WIN)});

    // Reset in the middle of a celebration.
    do_reset();
    step(0, 1, 1);
    idle(2);
    step(1, 0, 0);
    idle(HOLD + 3);
    step(0, 1, 0);
    chk("t5_left",  sk.leftScore, 1);
    chk("t5_right", sk.rightScore, 0);
    idle(HOLD + 2);

`ifdef SCORE_BLINK_EN
    do_reset();
    step(0, 1, 0);
    chk("t6_lhex0", sk.leftHex, 7'b1111001);
    step(0, 0, 0);
    chk("t6_lhex1", sk.leftHex, 7'b1111001);
    step(0, 0, 0);
    chk("t6_lhex2", sk.leftHex, 7'b1111111);
    step(0, 0, 0);
    chk("t6_lhex3", sk.leftHex, 7'b1111111);
    chk("t6_rhex",  sk.rightHex, 7'b1000000);
    idle(HOLD);
`endif

    // Randomized strobes with occasional resets.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) step(1, 0, 0);
      else step(0, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
    end

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
